// File: rtl/fht_frame_sched.sv
// -----------------------------------------------------------------------------
// fht_frame_sched
//
// Frame scheduler wrapped around the FHT core. It collects one frame of
// N = 4*2^A_BIT samples from an input valid/ready stream into the four data
// RAM banks. It then hands the banks to fht_control with a single-cycle start
// pulse and waits for the core to finish. Finally it streams the transformed
// frame back out of the banks as a valid/ready stream. The scheduler owns the
// bank-port mux select (oMEM_OWN), so the loader/unloader and the FHT datapath
// never drive the banks in the same cycle.
//
// Ports:
//   iCLK, iRESET                 clock, asynchronous active-low reset
//   iDATA/iVALID/oREADY          input sample stream
//   oDATA/oVALID/oLAST/iREADY    output sample stream, oLAST on sample N-1
//   oBANK_SEL/ADDR/WE/WDATA      bank port driven while oMEM_OWN = 0
//   iBANK_RDATA                  selected bank read data, 1-cycle latency
//   oMEM_OWN                     0: banks to scheduler, 1: banks to FHT core
//   oFHT_START, iFHT_RDY         start pulse to / idle flag from fht_control
//
// Build option:
//   FHT_SCHED_BITREV_EN  when defined, input samples arrive in natural order
//                        and are stored bit-reversed. When undefined, the
//                        source already supplies bit-reversed order.
// -----------------------------------------------------------------------------
`ifndef A_BIT
`define A_BIT 3
`endif

module fht_frame_sched #(
   parameter int A_BIT = `A_BIT,
   parameter int D_BIT = 16
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic [D_BIT-1:0] iDATA,
   input  logic             iVALID,
   output logic             oREADY,
   output logic [D_BIT-1:0] oDATA,
   output logic             oVALID,
   output logic             oLAST,
   input  logic             iREADY,
   output logic [1:0]       oBANK_SEL,
   output logic [A_BIT-1:0] oBANK_ADDR,
   output logic             oBANK_WE,
   output logic [D_BIT-1:0] oBANK_WDATA,
   input  logic [D_BIT-1:0] iBANK_RDATA,
   output logic             oMEM_OWN,
   output logic             oFHT_START,
   input  logic             iFHT_RDY
);

   localparam int IW = A_BIT + 2;                    // frame index width
   localparam logic [IW-1:0] IDX_LAST = '1;          // index N-1

   typedef enum logic [2:0] {
      S_LOAD,
      S_KICK,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_UNLOAD
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    k_q, k_d;          // load index
   logic [IW:0]      r_q, r_d;          // unload read index, runs to N
   logic [IW-1:0]    o_q, o_d;          // unload output index
   logic             inflight_q;        // read issued last cycle, data on iBANK_RDATA now
   logic [1:0]       cnt_q, cnt_d;      // entries stored in the skid FIFO
   logic             wr_ptr_q, rd_ptr_q;
   logic [D_BIT-1:0] fifo_q [2];
   logic [1:0]       sel_q;             // last bank select issued
   logic [A_BIT-1:0] addr_q;            // last bank address issued

   logic             wr_en, rd_en;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    load_idx;
   logic             out_valid, pop, store, unstore, last_pop;
   logic [D_BIT-1:0] fifo_head;

`ifdef FHT_SCHED_BITREV_EN
   function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      for (int b = 0; b < IW; b++) r[b] = v[IW-1-b];
      return r;
   endfunction

   assign load_idx = bitrev(k_q);
`else
   assign load_idx = k_q;
`endif

   // ---------------------------------------------------------------------------
   // Output skid FIFO. The word on iBANK_RDATA (inflight_q) is presented
   // directly when the FIFO is empty. This gives one-cycle read-to-valid
   // latency. A word that is not consumed in its cycle is stored. Stored
   // entries are always older than the in-flight word, so order is kept.
   // ---------------------------------------------------------------------------
   always_comb begin
      out_valid = (state_q == S_UNLOAD) && (inflight_q || (cnt_q != 2'd0));
      fifo_head = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : iBANK_RDATA;
      pop       = out_valid && iREADY;
      store     = inflight_q && !(pop && (cnt_q == 2'd0));
      unstore   = pop && (cnt_q != 2'd0);
      last_pop  = pop && (o_q == IDX_LAST);
      cnt_d     = cnt_q;
      if (store && !unstore) cnt_d = cnt_q + 2'd1;
      if (!store && unstore) cnt_d = cnt_q - 2'd1;
   end

   // ---------------------------------------------------------------------------
   // Next-state, counters and strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      r_d        = r_q;
      o_d        = o_q;
      oREADY     = 1'b0;
      oMEM_OWN   = 1'b0;
      oFHT_START = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      idx        = '0;
      case (state_q)
         S_LOAD: begin
            oREADY = 1'b1;
            if (iVALID) begin
               wr_en = 1'b1;
               idx   = load_idx;
               if (k_q == IDX_LAST) begin
                  state_d = S_KICK;
                  k_d     = '0;
               end else begin
                  k_d = k_q + IW'(1);
               end
            end
         end
         S_KICK: begin
            oMEM_OWN   = 1'b1;
            oFHT_START = 1'b1;
            state_d    = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // Wait for the core to acknowledge the start. Without this step,
            // the idle flag seen before the core reacts would be taken as done.
            oMEM_OWN = 1'b1;
            if (!iFHT_RDY) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            oMEM_OWN = 1'b1;
            if (iFHT_RDY) begin
               state_d = S_UNLOAD;
               r_d     = '0;
               o_d     = '0;
            end
         end
         S_UNLOAD: begin
            // Issue a read only while the FIFO can still accept it.
            if ((({1'b0, inflight_q} + cnt_q) < 2'd2) && !r_q[IW]) begin
               rd_en = 1'b1;
               idx   = r_q[IW-1:0];
               r_d   = r_q + (IW+1)'(1);
            end
            if (pop) begin
               if (last_pop) begin
                  state_d = S_LOAD;
                  r_d     = '0;
                  o_d     = '0;
               end else begin
                  o_d = o_q + IW'(1);
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and control registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q    <= S_LOAD;
         k_q        <= '0;
         r_q        <= '0;
         o_q        <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         sel_q      <= 2'd0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         r_q        <= r_d;
         o_q        <= o_d;
         inflight_q <= rd_en;
         if (last_pop) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            if (store)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (unstore) rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (wr_en || rd_en) begin
            sel_q  <= idx[1:0];
            addr_q <= idx[IW-1:2];
         end
      end
   end

   // NOTE: FIFO storage has no reset. Emptiness is tracked entirely by
   // cnt_q and the pointers, and oDATA is gated while oVALID is low.
   always_ff @(posedge iCLK) begin
      if (store) fifo_q[wr_ptr_q] <= iBANK_RDATA;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Bank address follows the access issued this cycle. It holds the last
   // issued value when the bank is idle.
   assign oBANK_SEL   = (wr_en || rd_en) ? idx[1:0]    : sel_q;
   assign oBANK_ADDR  = (wr_en || rd_en) ? idx[IW-1:2] : addr_q;
   assign oBANK_WE    = wr_en;
   assign oBANK_WDATA = wr_en ? iDATA : '0;
   assign oVALID      = out_valid;
   assign oDATA       = out_valid ? fifo_head : '0;
   assign oLAST       = out_valid && (o_q == IDX_LAST);

endmodule

// File: tb/tb_fht_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_fht_frame_sched
//
// Directed bench for fht_frame_sched with A_BIT = 3 (N = 32). A bank model
// returns addr*4+sel one cycle after the address. The transformed frame
// therefore reads back as 0..31 in natural order. iFHT_RDY is driven
// directly to play the role of fht_control.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fht_frame_sched;

   localparam int A_BIT = 3;
   localparam int D_BIT = 16;
   localparam int N     = 32;

   logic             iCLK = 1'b0;
   logic             iRESET;
   logic [D_BIT-1:0] iDATA;
   logic             iVALID;
   logic             oREADY;
   logic [D_BIT-1:0] oDATA;
   logic             oVALID;
   logic             oLAST;
   logic             iREADY;
   logic [1:0]       oBANK_SEL;
   logic [A_BIT-1:0] oBANK_ADDR;
   logic             oBANK_WE;
   logic [D_BIT-1:0] oBANK_WDATA;
   logic [D_BIT-1:0] iBANK_RDATA;
   logic             oMEM_OWN;
   logic             oFHT_START;
   logic             iFHT_RDY;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   always #5 iCLK = ~iCLK;

   fht_frame_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
      .iCLK        (iCLK),
      .iRESET      (iRESET),
      .iDATA       (iDATA),
      .iVALID      (iVALID),
      .oREADY      (oREADY),
      .oDATA       (oDATA),
      .oVALID      (oVALID),
      .oLAST       (oLAST),
      .iREADY      (iREADY),
      .oBANK_SEL   (oBANK_SEL),
      .oBANK_ADDR  (oBANK_ADDR),
      .oBANK_WE    (oBANK_WE),
      .oBANK_WDATA (oBANK_WDATA),
      .iBANK_RDATA (iBANK_RDATA),
      .oMEM_OWN    (oMEM_OWN),
      .oFHT_START  (oFHT_START),
      .iFHT_RDY    (iFHT_RDY)
   );

   // Bank model: registered read of the value addr*4+sel.
   always @(posedge iCLK) iBANK_RDATA <= {11'd0, oBANK_ADDR, oBANK_SEL};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected storage index for load sample k.
   function automatic logic [4:0] jmap(input int k);
      logic [4:0] kk;
      kk = 5'(k);
`ifdef FHT_SCHED_BITREV_EN
      for (int b = 0; b < 5; b++) jmap[b] = kk[4-b];
`else
      jmap = kk;
`endif
   endfunction

   task automatic next_cycle();
      @(posedge iCLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      // {ready, valid, last, own, start, we, sel[1:0], addr[2:0]}
      check({tag, "_ctl"}, {oREADY, oVALID, oLAST, oMEM_OWN, oFHT_START, oBANK_WE,
                            oBANK_SEL, oBANK_ADDR}, 32'b1_0_0_0_0_0_00_000);
      check({tag, "_data"}, {oDATA, oBANK_WDATA}, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      iRESET   = 1'b0;
      iVALID   = 1'b0;
      iDATA    = '0;
      iREADY   = 1'b0;
      iFHT_RDY = 1'b1;
      #1;
      check_idle(tag);
      @(posedge iCLK);
      @(posedge iCLK);
      #1;
      check_idle({tag, "_held"});
      iRESET = 1'b1;
   endtask

   // Stream samples 0..N-1 back-to-back. Ends in the KICK cycle.
   task automatic load_frame();
      logic [4:0] jj;
      for (int k = 0; k < N; k++) begin
         next_cycle();
         iDATA  = D_BIT'(k);
         iVALID = 1'b1;
         @(negedge iCLK);
         jj = jmap(k);
         check("load_ready", oREADY, 1);
         check("load_we", oBANK_WE, 1);
         check("load_wdata", oBANK_WDATA, k);
         check("load_sel", oBANK_SEL, jj[1:0]);
         check("load_addr", oBANK_ADDR, jj[4:2]);
         check("load_start", oFHT_START, 0);
      end
      next_cycle();
      iVALID = 1'b0;
      iDATA  = '0;
      @(negedge iCLK);
      check("kick_ready", oREADY, 0);
      check("kick_start", oFHT_START, 1);
      check("kick_own", oMEM_OWN, 1);
      check("kick_we", oBANK_WE, 0);
   endtask

   // Core model: busy from 3 cycles after start for low_len cycles. Ends in
   // the first UNLOAD cycle.
   task automatic fht_run(input int low_len);
      logic bad;
      bad = 1'b0;
      next_cycle();
      @(negedge iCLK);
      check("start_once", oFHT_START, 0);
      check("busy_own", oMEM_OWN, 1);
      next_cycle();
      @(negedge iCLK);
      if (!oMEM_OWN || oFHT_START || oREADY) bad = 1'b1;
      next_cycle();
      iFHT_RDY = 1'b0;
      for (int i = 0; i < low_len; i++) begin
         @(negedge iCLK);
         if (!oMEM_OWN || oFHT_START || oVALID || oREADY || oBANK_WE) bad = 1'b1;
         next_cycle();
      end
      iFHT_RDY = 1'b1;
      @(negedge iCLK);
      check("own_span_ok", bad, 0);
      check("done_own", oMEM_OWN, 1);
      check("done_valid", oVALID, 0);
      next_cycle();
      @(negedge iCLK);
      check("unload_own", oMEM_OWN, 0);
      check("unload_we", oBANK_WE, 0);
      check("unload_rd0", {oBANK_SEL, oBANK_ADDR}, 0);
      check("unload_valid0", oVALID, 0);
   endtask

   // Collect the output frame. If stop_at matches the presented index,
   // return before its handshake.
   task automatic unload(input bit rand_rdy, input int stop_at, output int ncyc);
      int exp;
      bit first;
      exp   = 0;
      ncyc  = 0;
      first = 1'b1;
      while (exp < N && ncyc < 400) begin
         next_cycle();
         iREADY = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
         @(negedge iCLK);
         if (first) check("first_valid", oVALID, 1);
         first = 1'b0;
         ncyc++;
         if (oVALID) begin
            check("out_data", oDATA, exp);
            check("out_last", oLAST, (exp == N-1) ? 1 : 0);
            if (exp == stop_at) return;
            if (iREADY) exp++;
         end else begin
            check("idle_last", oLAST, 0);
         end
      end
      check("out_count", exp, N);
      next_cycle();
      iREADY = 1'b0;
      @(negedge iCLK);
      check("back_to_load", {oREADY, oVALID, oMEM_OWN}, 3'b100);
   endtask

   initial begin
      iRESET   = 1'b0;
      iVALID   = 1'b0;
      iDATA    = '0;
      iREADY   = 1'b0;
      iFHT_RDY = 1'b1;

      do_reset("reset");

      // Full frame: long transform, random backpressure.
      load_frame();
      fht_run(200);
      unload(1'b1, -1, cyc);

      // Reset while the core is running.
      load_frame();
      repeat (3) next_cycle();
      iFHT_RDY = 1'b0;
      repeat (5) next_cycle();
      @(negedge iCLK);
      check("pre_rst_own", oMEM_OWN, 1);
      do_reset("rst_wait_done");

      // Reset while output 10 is presented.
      load_frame();
      fht_run(4);
      unload(1'b0, 10, cyc);
      do_reset("rst_unload");

      // Recovery frame with random backpressure.
      load_frame();
      fht_run(6);
      unload(1'b1, -1, cyc);

      // Full-rate unload: 32 outputs in 32 cycles.
      load_frame();
      fht_run(2);
      unload(1'b0, -1, cyc);
      check("throughput", cyc, N);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the flow itself stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fht_frame_sched.md
# fht_frame_sched

Frame scheduler around the FHT core. Loads one frame of input samples from a valid/ready stream into the four data RAM banks and hands the banks to `fht_control` with a one-cycle start pulse. After `fht_control` reports completion, reads the transformed frame back out of the banks as a valid/ready stream. It owns the bank-port mux select, so the loader/unloader and the FHT datapath never drive the banks in the same cycle.

## Interface
Parameters:
- `A_BIT`, default `` `A_BIT `` — bank address width; frame length N = 4·2^A_BIT points.
- `D_BIT`, default 16 — sample width.

Ports:
- `iCLK` in 1 — clock; all logic on rising edge.
- `iRESET` in 1 — asynchronous, active-low reset.
- `iDATA` in D_BIT — input sample.
- `iVALID` in 1 — input sample valid.
- `oREADY` out 1 — scheduler accepts input.
- `oDATA` out D_BIT — output sample.
- `oVALID` out 1 — output sample valid.
- `oLAST` out 1 — marks output sample N−1.
- `iREADY` in 1 — downstream accepts output.
- `oBANK_SEL` out 2 — bank addressed by the scheduler.
- `oBANK_ADDR` out A_BIT — address within the selected bank.
- `oBANK_WE` out 1 — write strobe for the selected bank.
- `oBANK_WDATA` out D_BIT — write data.
- `iBANK_RDATA` in D_BIT — read data of the selected bank; 1-cycle registered latency.
- `oMEM_OWN` out 1 — 0: banks muxed to the scheduler; 1: banks muxed to `fht_control`.
- `oFHT_START` out 1 — start pulse to `fht_control.iSTART`.
- `iFHT_RDY` in 1 — `fht_control.oRDY`; high when the core is idle.

## Operation
- FSM states: LOAD (reset state), KICK, WAIT_BUSY, WAIT_DONE, UNLOAD.
- LOAD:
  - `oREADY`=1 and `oMEM_OWN`=0.
  - Each handshake (`iVALID`&`oREADY`) writes `iDATA` at index k, with k running 0..N−1. Write outputs are combinational from the handshake and k: `oBANK_WE`=1, `oBANK_WDATA`=`iDATA`, and sel/addr from the index map.
  - The handshake at k=N−1 moves to KICK and clears k.
- Index map, applied to a (A_BIT+2)-bit index j: `oBANK_SEL`=j[1:0], `oBANK_ADDR`=j[A_BIT+1:2].
- KICK:
  - `oMEM_OWN`=1 and `oFHT_START`=1 for exactly this cycle.
  - Next state is WAIT_BUSY.
- WAIT_BUSY: `oMEM_OWN`=1; waits for `iFHT_RDY`=0, then moves to WAIT_DONE. It waits indefinitely; there is no timeout.
- WAIT_DONE: `oMEM_OWN`=1; on the first cycle with `iFHT_RDY`=1, moves to UNLOAD with the read counter r=0 and the output counter o=0.
- UNLOAD:
  - `oMEM_OWN`=0 and `oBANK_WE`=0.
  - A 2-entry skid FIFO holds returned data. A read is issued when (in-flight + stored) < 2 and r < N. The read drives sel/addr from r in natural order, then r++.
  - Returned data is pushed into the FIFO one cycle after its issue.
  - `oVALID` = FIFO not empty. `oDATA` = FIFO head. `oLAST` = `oVALID` & (o = N−1).
  - An output handshake pops the FIFO and increments o. The handshake at o=N−1 returns to LOAD.
- Idle bank outputs: when no write or read is issued, `oBANK_SEL`/`oBANK_ADDR` hold their last value and `oBANK_WE`=0.
- Reset, asserted at any time (including mid-frame or mid-transform):
  - Every output goes to 0, except `oREADY`=1 (LOAD state).
  - All counters and the FIFO are cleared.
  - A partially loaded frame is discarded. `fht_control` is reset by the same `iRESET`.

## Timing
- Input throughput: 1 sample/cycle in LOAD. `oREADY` drops in the cycle after the N-th handshake.
- Load to start: `oFHT_START` is asserted 1 cycle after the final input handshake.
- Done to output: `oMEM_OWN` falls on the first UNLOAD cycle (the cycle after `iFHT_RDY` is seen high). The first read is issued in that cycle, and the first `oVALID` follows 1 cycle later.
- Output throughput: 1 sample/cycle with `iREADY` held high. Arbitrary `iREADY` stalls lose and duplicate no samples.
- The FIFO never overflows. `oDATA` is stable while `oVALID`=1 & `iREADY`=0.
- `oLAST`→LOAD: `oREADY`=1 in the cycle after the last output handshake.
- `iVALID` is ignored outside LOAD. `iREADY` is ignored outside UNLOAD.

## Configuration
- `FHT_SCHED_BITREV_EN`:
  - Defined: in LOAD, j = bit-reverse of k over A_BIT+2 bits, so input arrives in natural order and is stored in the bit-reversed order the FHT stages expect. UNLOAD stays natural.
  - Undefined: j = k; the upstream source supplies bit-reversed order.

## Test plan
- Reset: hold `iRESET`=0 for 2 cycles → all outputs 0 except `oREADY`=1; state LOAD.
- Natural load (macro off, A_BIT=3, N=32): stream 0..31 back-to-back → 32 writes with sample 5 at sel=1, addr=1 and sample 31 at sel=3, addr=7. `oFHT_START` pulses once, 1 cycle after the last input. `oREADY`=0 afterwards.
- Bit-reverse load (macro on, N=32): sample k=1 → j=16, sel=0, addr=4. Sample k=6 → j=12, sel=0, addr=3.
- FHT handshake: model `iFHT_RDY` falling 3 cycles after start and rising 200 cycles later → `oMEM_OWN`=1 over exactly that span. `oVALID` rises 2 cycles after `iFHT_RDY` rises.
- Unload backpressure: bank model returns addr·4+sel; drive `iREADY` with a random 50% pattern → outputs 0..31 in order, no gaps or duplicates, `oLAST` only on 31, then `oREADY`=1.
- Mid-operation reset: assert `iRESET` during WAIT_DONE and again at output 10 of UNLOAD → immediate return to reset values. A following full frame completes correctly.
